// File: rtl/nms_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nms_pkg : shared types and constants for the 3x3 NMS keypoint stream       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package nms_pkg;

  localparam int SCORE_W_DFLT = 8;
  localparam int DEPTH_W_DFLT = 10;

  // Window edge length and input-to-output latency in clocks
  localparam int WIN = 3;
  localparam int LAT = 2;

  typedef struct packed {
    logic                    flag;
    logic [SCORE_W_DFLT-1:0] score;
    logic [DEPTH_W_DFLT-1:0] depth;
  } nms_pix_t;

endpackage
`default_nettype wire

// File: rtl/nms_line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nms_line_buffer : one-write / one-sync-read line store, old data on RDW    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nms_line_buffer #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 19,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/nms_stream_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nms_stream_3x3 : raster-scan 3x3 non-maximum suppression with coordinates  |
// | Option macro NMS_DEPTH_GATE_EN suppresses survivors whose depth is zero.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nms_stream_3x3
  import nms_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int SCORE_W = 8,
  parameter int DEPTH_W = 10,
  parameter int X_W     = 10,
  parameter int Y_W     = 9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_sof,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_flag,
  input  logic [DEPTH_W-1:0] i_depth,
  output logic               o_valid,
  output logic               o_flag,
  output logic [SCORE_W-1:0] o_score,
  output logic [DEPTH_W-1:0] o_depth,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic               o_eof
);

  localparam int c_pix_w = 1 + SCORE_W + DEPTH_W;

  logic [X_W-1:0]     r_col, w_col, w_col_nxt;
  logic [Y_W-1:0]     r_row, w_row, w_row_nxt;
  logic               w_col_last;
  logic [c_pix_w-1:0] w_pix, w_rd_a, w_rd_b, r_cur;

  logic [WIDTH-1:0]   r_vld_a, r_vld_b;
  logic [WIN-1:0]     r_c2v;
  logic               r_lbw_en;
  logic [X_W-1:0]     r_lbw_col;

  // Columns indexed left..right, rows top..bottom; the right column is live
  logic [WIN-2:0][WIN-1:0][c_pix_w-1:0] r_win;
  logic [WIN-2:0][WIN-1:0]              r_wv;
  logic [WIN-1:0][WIN-1:0][c_pix_w-1:0] w_win;
  logic [WIN-1:0][WIN-1:0]              w_wv;

  logic               r_s1_emit, r_s1_eof;
  logic [X_W-1:0]     r_s1_x;
  logic [Y_W-1:0]     r_s1_y;

  logic [WIN*WIN-1:0] w_blk;
  logic [c_pix_w-1:0] w_ctr;
  logic [SCORE_W-1:0] w_ctr_score;
  logic [DEPTH_W-1:0] w_ctr_depth;
  logic               w_surv, w_keep;

  logic               r_o_valid, r_o_flag, r_o_eof;
  logic [SCORE_W-1:0] r_o_score;
  logic [DEPTH_W-1:0] r_o_depth;
  logic [X_W-1:0]     r_o_x;
  logic [Y_W-1:0]     r_o_y;

  assign w_pix      = {i_flag, i_score, i_depth};
  assign w_col      = i_sof ? '0 : r_col;
  assign w_row      = i_sof ? '0 : r_row;
  assign w_col_last = (w_col == X_W'(WIDTH - 1));
  assign w_col_nxt  = w_col_last ? '0 : w_col + X_W'(1);
  assign w_row_nxt  = !w_col_last ? w_row :
                      (w_row == Y_W'(HEIGHT - 1)) ? '0 : w_row + Y_W'(1);

  // Line A holds row r-1; line B is refilled from line A's read one clock later
  nms_line_buffer #(.DEPTH(WIDTH), .DATA_W(c_pix_w), .ADDR_W(X_W)) u_lb_a (
    .i_clk   (i_clk),
    .i_we    (i_valid),
    .i_waddr (w_col),
    .i_wdata (w_pix),
    .i_re    (i_valid),
    .i_raddr (w_col),
    .o_rdata (w_rd_a)
  );

  nms_line_buffer #(.DEPTH(WIDTH), .DATA_W(c_pix_w), .ADDR_W(X_W)) u_lb_b (
    .i_clk   (i_clk),
    .i_we    (r_lbw_en),
    .i_waddr (r_lbw_col),
    .i_wdata (w_rd_a),
    .i_re    (i_valid),
    .i_raddr (w_col),
    .o_rdata (w_rd_b)
  );

  assign w_win = {{r_cur, w_rd_a, w_rd_b}, r_win};
  assign w_wv  = {r_c2v, r_wv};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_vld_a   <= '0;
      r_vld_b   <= '0;
      r_c2v     <= '0;
      r_wv      <= '0;
      r_lbw_en  <= 1'b0;
      r_s1_emit <= 1'b0;
    end else begin
      r_lbw_en  <= i_valid;
      r_s1_emit <= 1'b0;
      if (i_valid) begin
        r_col     <= w_col_nxt;
        r_row     <= w_row_nxt;
        r_s1_emit <= (w_row >= Y_W'(2)) && (w_col >= X_W'(2));
        if (i_sof) begin
          r_vld_a    <= '0;
          r_vld_a[0] <= 1'b1;
          r_vld_b    <= '0;
          r_c2v      <= 3'b100;
          r_wv       <= '0;
        end else begin
          r_vld_a[w_col] <= 1'b1;
          r_vld_b[w_col] <= r_vld_a[w_col];
          r_c2v          <= {1'b1, r_vld_a[w_col], r_vld_b[w_col]};
          r_wv           <= {r_c2v, r_wv[1]};
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_lbw_col <= w_col;
    if (i_valid) begin
      r_cur    <= w_pix;
      r_win    <= {w_win[2], r_win[1]};
      r_s1_x   <= w_col - X_W'(1);
      r_s1_y   <= w_row - Y_W'(1);
      r_s1_eof <= (w_row == Y_W'(HEIGHT - 1)) && w_col_last;
    end
  end

  // A flagged neighbour blocks the centre; ties go to the raster-later pixel
  function automatic logic nb_blocks(input logic [c_pix_w-1:0] nb, input logic nb_vld,
                                     input logic [SCORE_W-1:0] ctr, input logic later);
    logic [SCORE_W-1:0] s;
    s = nb[DEPTH_W +: SCORE_W];
    return nb[c_pix_w-1] && nb_vld && (later ? (ctr <= s) : (ctr < s));
  endfunction

  assign w_ctr       = w_win[1][1];
  assign w_ctr_score = w_ctr[DEPTH_W +: SCORE_W];
  assign w_ctr_depth = w_ctr[DEPTH_W-1:0];

  for (genvar gc = 0; gc < WIN; gc++) begin : g_col
    for (genvar gr = 0; gr < WIN; gr++) begin : g_row
      if (gc == 1 && gr == 1) begin : g_ctr
        assign w_blk[gc*WIN+gr] = 1'b0;
      end else begin : g_nb
        assign w_blk[gc*WIN+gr] = nb_blocks(w_win[gc][gr], w_wv[gc][gr], w_ctr_score,
                                            !((gr == 0) || (gr == 1 && gc == 0)));
      end
    end
  end

  assign w_surv = w_ctr[c_pix_w-1] && w_wv[1][1] && !(|w_blk);

`ifdef NMS_DEPTH_GATE_EN
  assign w_keep = w_surv && (w_ctr_depth != '0);
`else
  assign w_keep = w_surv;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_o_valid <= 1'b0;
      r_o_flag  <= 1'b0;
      r_o_score <= '0;
      r_o_depth <= '0;
      r_o_x     <= '0;
      r_o_y     <= '0;
      r_o_eof   <= 1'b0;
    end else begin
      r_o_valid <= r_s1_emit;
      r_o_flag  <= r_s1_emit && w_keep;
      r_o_score <= (r_s1_emit && w_keep) ? w_ctr_score : '0;
      r_o_depth <= (r_s1_emit && w_keep) ? w_ctr_depth : '0;
      r_o_x     <= r_s1_emit ? r_s1_x : '0;
      r_o_y     <= r_s1_emit ? r_s1_y : '0;
      r_o_eof   <= r_s1_emit && r_s1_eof;
    end
  end

  assign o_valid = r_o_valid;
  assign o_flag  = r_o_flag;
  assign o_score = r_o_score;
  assign o_depth = r_o_depth;
  assign o_x     = r_o_x;
  assign o_y     = r_o_y;
  assign o_eof   = r_o_eof;

endmodule
`default_nettype wire

// File: tb/tb_nms_stream_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nms_stream_3x3 : directed scoreboard bench for nms_stream_3x3 (8x6)     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_nms_stream_3x3;
  import nms_pkg::*;

  localparam int W = 8, H = 6, SW = 8, DW = 10, XW = 3, YW = 3;
`ifdef NMS_DEPTH_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, vin, sof, flag;
  logic [SW-1:0] score;
  logic [DW-1:0] depth;
  logic ov, oflag, oeof;
  logic [SW-1:0] oscore;
  logic [DW-1:0] odepth;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;

  always #5 clk = ~clk;

  nms_stream_3x3 #(.WIDTH(W), .HEIGHT(H), .SCORE_W(SW), .DEPTH_W(DW), .X_W(XW), .Y_W(YW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vin), .i_sof(sof), .i_score(score), .i_flag(flag),
    .i_depth(depth), .o_valid(ov), .o_flag(oflag), .o_score(oscore), .o_depth(odepth),
    .o_x(ox), .o_y(oy), .o_eof(oeof)
  );

  typedef struct {
    logic [25:0] bits;
    int          cyc;
  } exp_t;

  exp_t     q[$];
  exp_t     m_e;
  int       checks = 0, errors = 0, cyc = 0;
  nms_pix_t img[H][W];
  nms_pix_t rnd[2][H][W];
  int       m_row = 0, m_col = 0;
  int       n_out = 0, n_surv = 0, n_eof = 0;
  int       s_x = 0, s_y = 0, s_score = 0, s_depth = 0, e_x = 0, e_y = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] model(input int y, input int x);
    nms_pix_t ct, nb;
    logic     s;
    ct = img[y][x];
    s  = ct.flag;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dy != 0 || dx != 0) begin
          nb = img[y+dy][x+dx];
          if (nb.flag) begin
            if (dy < 0 || (dy == 0 && dx < 0)) begin
              if (ct.score < nb.score) s = 1'b0;
            end else if (ct.score <= nb.score) s = 1'b0;
          end
        end
      end
    end
    if (GATE && ct.depth == '0) s = 1'b0;
    return {s, s ? ct.score : 8'd0, s ? ct.depth : 10'd0, 3'(x), 3'(y),
            (x == W - 2 && y == H - 2)};
  endfunction

  function automatic nms_pix_t gen(input int pat, input int r, input int c);
    nms_pix_t p;
    p.flag  = 1'b1;
    p.score = (r == 3 && c == 4) ? 8'd200 : 8'd10;
    p.depth = DW'(r * 8 + c + 1);
    case (pat)
      1: begin
        p.flag  = (r == 2 && (c == 2 || c == 3));
        p.score = p.flag ? 8'd50 : 8'd0;
      end
      2, 3: p = rnd[pat-2][r][c];
      4: if (r == 3 && c == 4) p.depth = '0;
      5: if (r == 3 && c == 4) p.depth = 10'd37;
      default: ;
    endcase
    return p;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vin = 1'b0;
      sof = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input logic s, input nms_pix_t p);
    exp_t e;
    @(negedge clk);
    vin = 1'b1; sof = s; flag = p.flag; score = p.score; depth = p.depth;
    if (s) begin
      m_row = 0;
      m_col = 0;
    end
    img[m_row][m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      e.bits = model(m_row - 1, m_col - 1);
      e.cyc  = cyc + 2;
      q.push_back(e);
    end
    if (m_col == W - 1) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end else m_col++;
  endtask

  task automatic send_frame(input int pat, input bit gaps, input int nbeats, input bit tail);
    for (int i = 0; i < nbeats; i++) begin
      send(i == 0, gen(pat, i / W, i % W));
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    if (tail) idle(1);
  endtask

  // Monitor: pops the scoreboard on every output beat
  initial forever begin
    @(negedge clk);
    if (ov) begin
      chk_eq("out_expected", (q.size() > 0) ? 1 : 0, 1);
      if (q.size() > 0) begin
        m_e = q.pop_front();
        chk_eq("out_fields", int'({oflag, oscore, odepth, ox, oy, oeof}), int'(m_e.bits));
        chk_eq("out_latency", cyc, m_e.cyc);
      end
      n_out++;
      if (oflag) begin
        n_surv++;
        s_x = int'(ox); s_y = int'(oy); s_score = int'(oscore); s_depth = int'(odepth);
      end
      if (oeof) begin
        n_eof++;
        e_x = int'(ox); e_y = int'(oy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_out, b_surv, b_eof;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          rnd[p][r][c].flag  = ($urandom_range(0, 3) != 0);
          rnd[p][r][c].score = 8'($urandom_range(0, 3));
          rnd[p][r][c].depth = 10'($urandom_range(0, 1023));
        end
    rst = 1'b1; vin = 1'b0; sof = 1'b0; flag = 1'b0; score = '0; depth = '0;
    repeat (3) @(negedge clk);
    chk_eq("rst_valid", int'(ov), 0);
    chk_eq("rst_flag", int'(oflag), 0);
    chk_eq("rst_score", int'(oscore), 0);
    chk_eq("rst_depth", int'(odepth), 0);
    chk_eq("rst_xy", int'({ox, oy}), 0);
    chk_eq("rst_eof", int'(oeof), 0);
    rst = 1'b0;

    // Single peak on a flat plateau
    b_out = n_out; b_surv = n_surv;
    send_frame(0, 1'b0, W * H, 1'b1); idle(6);
    chk_eq("peak_outputs", n_out - b_out, 24);
    chk_eq("peak_survivors", n_surv - b_surv, 1);
    chk_eq("peak_xy", s_x * 16 + s_y, 4 * 16 + 3);
    chk_eq("peak_score", s_score, 200);

    // Horizontal tie: raster-later pixel wins
    b_surv = n_surv;
    send_frame(1, 1'b0, W * H, 1'b1); idle(6);
    chk_eq("tie_survivors", n_surv - b_surv, 1);
    chk_eq("tie_xy", s_x * 16 + s_y, 3 * 16 + 2);

    // Random scores with input gaps
    b_out = n_out; b_eof = n_eof;
    send_frame(2, 1'b1, W * H, 1'b1); idle(6);
    chk_eq("gap_outputs", n_out - b_out, 24);
    chk_eq("gap_eof_count", n_eof - b_eof, 1);
    chk_eq("gap_eof_xy", e_x * 16 + e_y, 6 * 16 + 4);

    // Frame restart at old pixel (3,5) with beats still in flight
    b_out = n_out; b_eof = n_eof;
    send_frame(2, 1'b0, 3 * W + 5, 1'b0);
    send_frame(3, 1'b0, W * H, 1'b1); idle(6);
    chk_eq("sof_outputs", n_out - b_out, 33);
    chk_eq("sof_eof_count", n_eof - b_eof, 1);

    // Reset mid-frame drops in-flight beats
    send_frame(3, 1'b0, 20, 1'b0);
    @(negedge clk); rst = 1'b1; vin = 1'b0; sof = 1'b0;
    @(posedge clk); #1 q.delete();
    @(negedge clk);
    chk_eq("rst_mid_outputs", int'({ov, oflag, oscore, odepth, ox, oy, oeof}), 0);
    rst = 1'b0;
    b_out = n_out; b_eof = n_eof;
    send_frame(2, 1'b1, W * H, 1'b1); idle(6);
    chk_eq("post_rst_outputs", n_out - b_out, 24);
    chk_eq("post_rst_eof", n_eof - b_eof, 1);

    // Depth gating of the peak
    b_surv = n_surv;
    send_frame(4, 1'b0, W * H, 1'b1); idle(6);
    chk_eq("depth0_survivors", n_surv - b_surv, GATE ? 0 : 1);
    b_surv = n_surv;
    send_frame(5, 1'b0, W * H, 1'b1); idle(6);
    chk_eq("depth37_survivors", n_surv - b_surv, 1);
    chk_eq("depth37_depth", s_depth, 37);

    chk_eq("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
